// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin front end that shares one multicycle aes_128 core among
// NUM_REQ requesters, with one block in flight and a one-entry result buffer.

module aes_core_arbiter_lane #(
   parameter int ID_W = 2,
   parameter int IDX  = 0
) (
   input  logic            launch,
   input  logic [ID_W-1:0] winner,
   input  logic            buf_full,
   input  logic [ID_W-1:0] buf_id,
   input  logic            resp_rdy,
   output logic            req_rdy,
   output logic            resp_vld,
   output logic            pop
);
   assign req_rdy  = launch & (winner == ID_W'(IDX));
   assign resp_vld = buf_full & (buf_id == ID_W'(IDX));
   assign pop      = resp_vld & resp_rdy;
endmodule

module aes_core_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_data,
   input  logic [NUM_REQ*128-1:0] req_key,
   output logic [NUM_REQ-1:0]     resp_valid,
   input  logic [NUM_REQ-1:0]     resp_ready,
   output logic [127:0]           resp_data,
   output logic [127:0]           core_in_bus,
   output logic [127:0]           core_key,
   input  logic                   core_ready,
   input  logic                   core_valid,
   input  logic [127:0]           core_out_bus,
   output logic                   proto_err
);
   logic [127:0]        data_arr [NUM_REQ];
   logic [127:0]        key_arr  [NUM_REQ];
   logic [NUM_REQ-1:0]  pop_vec;
   logic [ID_W-1:0]     winner;
   logic                any_valid;
   logic                launch;
   logic                pop;

   logic                pend_q;
   logic                pend_real_q;
   logic [ID_W-1:0]     pend_id_q;
   logic                buf_full_q;
   logic [ID_W-1:0]     buf_id_q;
   logic [127:0]        buf_q;
   logic [ID_W-1:0]     rr_last_q;
   logic                proto_err_q;
   logic                started_q;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign data_arr[i] = req_data[128*i +: 128];
      assign key_arr[i]  = req_key[128*i +: 128];

      aes_core_arbiter_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
         .launch   (launch),
         .winner   (winner),
         .buf_full (buf_full_q),
         .buf_id   (buf_id_q),
         .resp_rdy (resp_ready[i]),
         .req_rdy  (req_ready[i]),
         .resp_vld (resp_valid[i]),
         .pop      (pop_vec[i])
      );
   end

   // Scan from farthest to nearest offset so the nearest valid requester after rr_last_q wins.
   always_comb begin
      int idx;
      idx    = 0;
      winner = rr_last_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(rr_last_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_valid[ID_W'(idx)]) winner = ID_W'(idx);
      end
   end

   assign any_valid   = |req_valid;
   assign launch      = core_ready & any_valid & ~buf_full_q & ~(pend_q & pend_real_q);
   assign pop         = |pop_vec;
   assign core_in_bus = any_valid ? data_arr[winner] : '0;
   assign core_key    = any_valid ? key_arr[winner]  : '0;
   assign resp_data   = buf_q;
   assign proto_err   = proto_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= 1'b0;
         pend_real_q <= 1'b0;
         pend_id_q   <= '0;
         buf_full_q  <= 1'b0;
         buf_id_q    <= '0;
         buf_q       <= '0;
         rr_last_q   <= ID_W'(NUM_REQ-1);
         proto_err_q <= 1'b0;
         started_q   <= 1'b0;
      end else begin
         if (core_ready) started_q <= 1'b1;

         if (core_valid & pend_q & pend_real_q) begin
            buf_q      <= core_out_bus;
            buf_id_q   <= pend_id_q;
            buf_full_q <= 1'b1;
         end else if (pop) begin
            buf_full_q <= 1'b0;
         end

         // A new block start overrides the completing block's pend clear.
         if (core_ready) begin
            pend_q      <= 1'b1;
            pend_real_q <= launch;
            pend_id_q   <= winner;
            if (launch) rr_last_q <= winner;
         end else if (core_valid & pend_q) begin
            pend_q      <= 1'b0;
            pend_real_q <= 1'b0;
         end

         // A stray core_valid before the first block start after reset belongs to a discarded block.
         if ((core_ready & pend_q & ~core_valid) | (core_valid & ~pend_q & started_q))
            proto_err_q <= 1'b1;
      end
   end
endmodule
